mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DWELL_W, default 4, SHALL set the width of the per-channel dwell count.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request one scan pass; accepted only in IDLE.
REQ-005 abort  input  1  SHALL synchronously cancel a pass in progress.
REQ-006 dwell  input  DWELL_W  SHALL give extra settle cycles per channel; latched on accepted start.
REQ-007 chan_en  input  4  SHALL be the channel-enable mask, bit i = mux input i; latched on accepted start.
REQ-008 y_in  input  1  SHALL be the downstream 4:1 mux output, sampled at capture.
REQ-009 sel  output  2  SHALL drive the 4:1 mux select; registered.
REQ-010 busy  output  1  SHALL be high while in DWELL.
REQ-011 done  output  1  SHALL be a one-cycle pulse marking pass completion.
REQ-012 sample  output  4  SHALL hold the last completed pass result, bit i = captured y_in of channel i.

Function
REQ-013 FSM states SHALL be IDLE, DWELL and DONE.
REQ-014 IDLE, start=1, latched chan_en!=0: next state DWELL, sel = lowest enabled index, counter = dwell, work register cleared.
REQ-015 IDLE, start=1, chan_en==0: next state DONE directly; sample loaded with 4'b0000.
REQ-016 DWELL, counter!=0: counter decrements by 1; sel held.
REQ-017 DWELL, counter==0: y_in captured into work[sel] at that edge.
REQ-018 After a capture, if a higher-index enabled channel exists: sel = next higher enabled index, counter reloaded from latched dwell, stay in DWELL.
REQ-019 After a capture, if no higher-index enabled channel exists: sample <= work with the new bit merged, next state DONE.
REQ-020 Each enabled channel SHALL occupy exactly dwell+1 cycles; disabled channels SHALL be skipped with zero cycles.
REQ-021 Latency SHALL be N*(dwell+1) cycles from the start-accepting edge until done is high, N = number of enabled channels.
REQ-022 Sample bits of disabled channels SHALL read 0.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 start in DWELL or DONE SHALL be ignored and SHALL NOT be queued.
REQ-025 Changes to dwell or chan_en after an accepted start SHALL NOT affect the pass in progress.
REQ-026 abort=1 in DWELL: next state IDLE, no done pulse, sample unchanged, sel holds its current value.
REQ-027 abort SHALL have priority over a simultaneous capture.
REQ-028 abort in IDLE or DONE SHALL have no effect; done still pulses if in DONE.
REQ-029 start and abort both high in IDLE: start SHALL be accepted.
REQ-030 sel SHALL hold its last value in IDLE and DONE.
REQ-031 Counter wrap SHALL be impossible: decrement occurs only when counter!=0.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, sel=2'd0, busy=0, done=0, sample=4'b0000, counter=0 and work=0, independent of clk.
REQ-033 Reset asserted mid-pass SHALL discard the pass; no done pulse after release.
REQ-034 The first start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-035 dwell=0, chan_en=4'b1111, mux inputs a=4'b1010, start pulsed -> sel steps 0,1,2,3 on consecutive cycles; done high 4 cycles after the start edge; sample=4'b1010.
REQ-036 dwell=2, chan_en=4'b0101, a=4'b1111 -> sel=0 for 3 cycles, then sel=2 for 3 cycles; done at cycle 6; sample=4'b0101.
REQ-037 chan_en=4'b0000, start -> done high the next cycle; busy never high; sample=4'b0000.
REQ-038 dwell=3, chan_en=4'b1111, abort in the 6th DWELL cycle -> IDLE next cycle, no done pulse, sample keeps its previous value, a new start is accepted.
REQ-039 start held high throughout a pass, then dwell/chan_en changed mid-pass -> exactly one pass with the originally latched values; a second pass starts only from IDLE.
REQ-040 rst_n pulsed low mid-DWELL, asynchronous to clk -> outputs at reset values immediately; no done pulse after release.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan controller stepping a 4:1 mux over enabled channels,
// dwelling per channel before capturing y_in into a result.
module mux_scan_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         chan_en,
  input  logic               y_in,
  output logic [1:0]         sel,
  output logic               busy,
  output logic               done,
  output logic [3:0]         sample
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DWELL = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]         state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic [3:0]         en_q;
  logic [3:0]         work;

  logic [1:0] first_ch;
  logic       has_next;
  logic [1:0] next_ch;
  logic [3:0] work_cap;

  // Lowest enabled channel of the incoming mask, used at start
  always_comb begin
    first_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (chan_en[i]) first_ch = 2'(i);
    end
  end

  // Next enabled channel above the current select, if any
  always_comb begin
    has_next = 1'b0;
    next_ch  = sel;
    for (int i = 3; i >= 0; i--) begin
      if (en_q[i] && (3'(i) > {1'b0, sel})) begin
        has_next = 1'b1;
        next_ch  = 2'(i);
      end
    end
  end

  // Work register with this cycle's capture merged in
  always_comb begin
    work_cap      = work;
    work_cap[sel] = y_in;
  end

  // Pass sequencing: dwell countdown, capture, channel advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= 2'd0;
      cnt     <= '0;
      dwell_q <= '0;
      en_q    <= 4'd0;
      work    <= 4'd0;
      sample  <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dwell_q <= dwell;
            en_q    <= chan_en;
            work    <= 4'd0;
            if (chan_en == 4'd0) begin
              sample <= 4'd0;
              state  <= DONE;
            end else begin
              sel   <= first_ch;
              cnt   <= dwell;
              state <= DWELL;
            end
          end
        end
        DWELL: begin
          if (abort) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            work <= work_cap;
            if (has_next) begin
              sel <= next_ch;
              cnt <= dwell_q;
            end else begin
              sample <= work_cap;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == DWELL);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioral 4:1 mux
// feeding y_in from the select output.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] dwell = 4'd0;
  logic [3:0] chan_en = 4'd0;
  logic [3:0] a = 4'd0;
  logic       y_in;
  logic [1:0] sel;
  logic       busy;
  logic       done;
  logic [3:0] sample;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign y_in = a[sel];

  mux_scan_ctrl #(.DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dwell(dwell), .chan_en(chan_en), .y_in(y_in),
    .sel(sel), .busy(busy), .done(done), .sample(sample)
  );

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #3;
    chk("rst_sel", {2'b0, sel}, 4'd0);
    chk("rst_busy", {3'b0, busy}, 4'd0);
    chk("rst_done", {3'b0, done}, 4'd0);
    chk("rst_sample", sample, 4'd0);
    step();
    rst_n = 1'b1;

    // dwell 0, all channels, a=1010
    step();
    dwell = 4'd0; chan_en = 4'b1111; a = 4'b1010; start = 1'b1;
    step(); start = 1'b0;
    chk("p1_sel0", {2'b0, sel}, 4'd0);
    chk("p1_busy", {3'b0, busy}, 4'd1);
    step(); chk("p1_sel1", {2'b0, sel}, 4'd1);
    step(); chk("p1_sel2", {2'b0, sel}, 4'd2);
    step(); chk("p1_sel3", {2'b0, sel}, 4'd3);
    chk("p1_nodone", {3'b0, done}, 4'd0);
    step(); chk("p1_done", {3'b0, done}, 4'd1);
    chk("p1_sample", sample, 4'b1010);
    chk("p1_busy_dn", {3'b0, busy}, 4'd0);
    step(); chk("p1_done_off", {3'b0, done}, 4'd0);
    chk("p1_sel_hold", {2'b0, sel}, 4'd3);

    // dwell 3, abort in 6th DWELL cycle
    dwell = 4'd3; chan_en = 4'b1111; a = 4'b0101; start = 1'b1;
    step(); start = 1'b0;
    for (int k = 2; k <= 6; k++) step();
    chk("ab_sel", {2'b0, sel}, 4'd1);
    chk("ab_busy", {3'b0, busy}, 4'd1);
    abort = 1'b1;
    step(); abort = 1'b0;
    chk("ab_idle", {3'b0, busy}, 4'd0);
    chk("ab_selhold", {2'b0, sel}, 4'd1);
    chk("ab_nodone", {3'b0, done}, 4'd0);
    chk("ab_sample", sample, 4'b1010);
    step(); chk("ab_nodone2", {3'b0, done}, 4'd0);
    dwell = 4'd0; chan_en = 4'b0010; a = 4'b0010; start = 1'b1;
    step(); start = 1'b0;
    chk("ab_restart", {3'b0, busy}, 4'd1);
    chk("ab_rs_sel", {2'b0, sel}, 4'd1);
    step(); chk("ab_rs_done", {3'b0, done}, 4'd1);
    chk("ab_rs_smp", sample, 4'b0010);

    // dwell 2, channels 0 and 2
    step();
    dwell = 4'd2; chan_en = 4'b0101; a = 4'b1111; start = 1'b1;
    step(); start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk("p2_sel", {2'b0, sel}, (k <= 3) ? 4'd0 : 4'd2);
      chk("p2_busy", {3'b0, busy}, 4'd1);
      step();
    end
    chk("p2_done", {3'b0, done}, 4'd1);
    chk("p2_sample", sample, 4'b0101);

    // empty mask
    step();
    chan_en = 4'b0000; start = 1'b1;
    step(); start = 1'b0;
    chk("p3_done", {3'b0, done}, 4'd1);
    chk("p3_busy", {3'b0, busy}, 4'd0);
    chk("p3_sample", sample, 4'b0000);
    step(); chk("p3_done_off", {3'b0, done}, 4'd0);
    chk("p3_busy2", {3'b0, busy}, 4'd0);

    // start held, config changed mid-pass
    dwell = 4'd1; chan_en = 4'b0011; a = 4'b0110; start = 1'b1;
    step();
    dwell = 4'd3; chan_en = 4'b1111;
    chk("p4_sel0a", {2'b0, sel}, 4'd0);
    step(); chk("p4_sel0b", {2'b0, sel}, 4'd0);
    step(); chk("p4_sel1a", {2'b0, sel}, 4'd1);
    step(); chk("p4_sel1b", {2'b0, sel}, 4'd1);
    step(); chk("p4_done", {3'b0, done}, 4'd1);
    chk("p4_sample", sample, 4'b0010);
    step(); chk("p4_idle", {3'b0, busy}, 4'd0);
    chk("p4_done_off", {3'b0, done}, 4'd0);
    step(); chk("p4_second", {3'b0, busy}, 4'd1);
    chk("p4_sec_sel", {2'b0, sel}, 4'd0);
    start = 1'b0;
    step(); step();
    chk("p4_sec_sel2", {2'b0, sel}, 4'd0);

    // asynchronous reset mid-DWELL
    #2 rst_n = 1'b0;
    #1;
    chk("ar_sel", {2'b0, sel}, 4'd0);
    chk("ar_busy", {3'b0, busy}, 4'd0);
    chk("ar_done", {3'b0, done}, 4'd0);
    chk("ar_sample", sample, 4'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("ar_nodone", {busy, done, 2'b0}, 4'd0);
    end
    dwell = 4'd0; chan_en = 4'b0001; a = 4'b0001;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    chk("rs_first", {3'b0, busy}, 4'd1);
    step(); chk("rs_done", {3'b0, done}, 4'd1);
    chk("rs_sample", sample, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
